mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access (MEM) stage of the RISC-V pipeline, directly upstream of write-back. It accepts one instruction at a time from execute and performs loads and stores over a request/acknowledge data-memory port. Loads get byte-lane extraction and sign or zero extension. Every instruction is delivered to write-back as a single-cycle `wb_valid` beat carrying destination register, write enable and data.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `REG_AW`, 5, register index width

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute presents an instruction.
- `ex_ready` out 1: the stage can accept an instruction (high only in IDLE).
- `ex_alu_result` in XLEN: effective address, or ALU result for non-memory ops.
- `ex_store_data` in XLEN: rs2 value for stores.
- `ex_rd` in REG_AW: destination register.
- `ex_reg_write` in 1: instruction writes rd.
- `ex_mem_read` in 1: load.
- `ex_mem_write` in 1: store.
- `ex_funct3` in 3: access size and sign.
- `dmem_req` out 1: memory request, held until ack.
- `dmem_we` out 1: write request.
- `dmem_addr` out XLEN: word-aligned address, with bits [1:0] = 0.
- `dmem_wdata` out XLEN: lane-replicated store data.
- `dmem_be` out 4: byte enables; 0 on reads.
- `dmem_ack` in 1: request complete; `dmem_rdata` is valid when it is high.
- `dmem_rdata` in XLEN: read word.
- `wb_valid` out 1: one-cycle pulse per retired instruction.
- `wb_rd` out REG_AW: destination register to write-back.
- `wb_reg_write` out 1: write enable to write-back.
- `wb_data` out XLEN: value to write.
- `wb_fault` out 1: misaligned or illegal access; write suppressed.

## Operation
- FSM states:
  - IDLE: `ex_ready` = 1.
  - MEM: request outstanding.
  - IDLE→MEM on an accepted load or store that is legal and aligned.
  - MEM→IDLE on the edge where `dmem_ack` = 1.
- On accept (`ex_valid` & `ex_ready`), all ex_* fields are latched. Downstream logic uses only the latched copies.
- Non-memory op (neither `ex_mem_read` nor `ex_mem_write`): stay in IDLE. Next cycle `wb_valid` = 1 and `wb_data` = `alu_result`.
- Loads, by funct3:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Extract the lane selected by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Stores, by funct3:
  - 000 SB: `be` = 0001 << addr[1:0]; `wdata` = byte replicated ×4.
  - 001 SH: `be` = 0011 << addr[1:0]; `wdata` = half replicated ×2.
  - 010 SW: `be` = 1111.
- `wb_reg_write` is 0 for stores. It is also forced to 0 when rd = 0.
- A fault is any of:
  - halfword with addr[0] ≠ 0;
  - word with addr[1:0] ≠ 0;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010;
  - `ex_mem_read` & `ex_mem_write` both set.
- On a fault: no `dmem_req` is issued. Next cycle `wb_valid` = 1, `wb_fault` = 1, `wb_reg_write` = 0, `wb_data` = 0.
- Write-back applies no backpressure, so `wb_valid` is never held.

## Timing
- Reset values: `ex_ready` = 1 after release. All of `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `wb_valid`, `wb_rd`, `wb_reg_write`, `wb_data`, `wb_fault` = 0. State = IDLE.
- Non-memory op or fault: accepted at edge N, `wb_valid` high for cycle N+1 only. Throughput is one instruction per cycle.
- Memory op: accepted at edge N.
  - `dmem_req` and the address/data/`be` outputs are registered and high from cycle N+1.
  - They stay stable until the edge where `dmem_ack` is sampled high, at edge N+1+k.
  - `wb_valid` is high for the cycle after that edge. Latency = k+2, where k ≥ 0 wait cycles.
  - `dmem_req` drops in the same cycle that `wb_valid` rises.
- `dmem_ack` while `dmem_req` = 0 is ignored.
- `ex_ready` = 0 throughout MEM. `ex_ready` returns to 1 in the `wb_valid` cycle, so the next instruction can be accepted then (back-to-back).
- Reset asserted mid-request: `dmem_req` deasserts asynchronously, the FSM returns to IDLE, and the in-flight instruction is dropped with no `wb_valid`.

## Structure
- Package `riscv_mem_pkg` holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum {ST_IDLE, ST_MEM};
  - width localparams.
- Sub-module `load_align`: combinational. Inputs: rdata, addr[1:0], funct3. Output: the extended XLEN result. It is reused by the debug memory path.

## Test plan
- ADD result 0x0000_1234, rd = 5, non-memory: `wb_valid` at N+1 with `wb_rd` = 5, `wb_data` = 0x1234, `wb_reg_write` = 1.
- LB at 0x103 with `rdata` = 0x80FF_0000 and ack after 2 waits: `wb_data` = 0xFFFF_FF80, `wb_valid` at N+4.
- SH at 0x202, store data 0xABCD_BEEF, zero-wait ack: `dmem_addr` = 0x200, `be` = 1100, `wdata` = 0xBEEF_BEEF, `wb_reg_write` = 0.
- LW at 0x101: no `dmem_req`; `wb_fault` = 1, `wb_reg_write` = 0 at N+1.
- Back-to-back LHU at 0x0 (rdata = 0x0000_F00D) then ADD: first beat `wb_data` = 0x0000_F00D, second beat exactly one cycle later.
- Reset during MEM with ack pending: `dmem_req` = 0 immediately, no `wb_valid`, `ex_ready` = 1 after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types, funct3 codes and access checks for the MEM stage
package riscv_mem_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int FUNCT3_W   = 3;
    localparam int BE_W       = 4;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_MEM
    } state_t;

    // True when a memory op must not reach the bus: bad size code, misaligned, or read+write together.
    function automatic logic access_fault(input logic                mem_read,
                                          input logic                mem_write,
                                          input logic [FUNCT3_W-1:0] funct3,
                                          input logic [1:0]          addr_lo);
        logic f;
        f = 1'b0;
        if (mem_read && mem_write) begin
            f = 1'b1;
        end else if (mem_read) begin
            case (funct3)
                F3_B, F3_BU: f = 1'b0;
                F3_H, F3_HU: f = addr_lo[0];
                F3_W:        f = (addr_lo != 2'b00);
                default:     f = 1'b1;
            endcase
        end else if (mem_write) begin
            case (funct3)
                F3_B:    f = 1'b0;
                F3_H:    f = addr_lo[0];
                F3_W:    f = (addr_lo != 2'b00);
                default: f = 1'b1;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - byte-lane extraction and sign/zero extension of a loaded word
import riscv_mem_pkg::*;

module load_align #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     rdata,
    input  logic [1:0]          addr,
    input  logic [FUNCT3_W-1:0] funct3,
    output logic [XLEN-1:0]     result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = rdata[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
            F3_W:    result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V MEM stage: load/store over req/ack port, one wb beat per instruction
import riscv_mem_pkg::*;

module mem_access_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [XLEN-1:0]     ex_alu_result,
    input  logic [XLEN-1:0]     ex_store_data,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [2:0]          ex_funct3,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic                dmem_ack,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_rd,
    output logic                wb_reg_write,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_fault
);

    state_t state, state_nxt;

    logic                accept;
    logic                is_mem;
    logic                fault;
    logic                go_mem;
    logic                mem_done;
    logic [BE_W-1:0]     store_be;
    logic [XLEN-1:0]     store_wdata;
    logic [XLEN-1:0]     load_data;

    // Copies of the accepted instruction that the completion path relies on.
    logic [1:0]          lat_addr_lo;
    logic [FUNCT3_W-1:0] lat_funct3;
    logic [REG_AW-1:0]   lat_rd;
    logic                lat_reg_write;
    logic                lat_mem_read;

    assign ex_ready = (state == ST_IDLE);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_read || ex_mem_write;
    assign fault    = access_fault(ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result[1:0]);
    assign go_mem   = accept && is_mem && !fault;
    assign mem_done = (state == ST_MEM) && dmem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go_mem)   state_nxt = ST_MEM;
            ST_MEM:  if (dmem_ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = ex_store_data;
        case (ex_funct3)
            F3_B: begin
                store_be    = 4'b0001 << ex_alu_result[1:0];
                store_wdata = {(XLEN/8){ex_store_data[7:0]}};
            end
            F3_H: begin
                store_be    = 4'b0011 << ex_alu_result[1:0];
                store_wdata = {(XLEN/16){ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem_rdata),
        .addr   (lat_addr_lo),
        .funct3 (lat_funct3),
        .result (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            wb_fault      <= 1'b0;
            lat_addr_lo   <= '0;
            lat_funct3    <= '0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_mem_read  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                lat_addr_lo   <= ex_alu_result[1:0];
                lat_funct3    <= ex_funct3;
                lat_rd        <= ex_rd;
                lat_reg_write <= ex_reg_write;
                lat_mem_read  <= ex_mem_read;
                if (go_mem) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= ex_mem_write;
                    dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
                    dmem_wdata <= ex_mem_write ? store_wdata : '0;
                    dmem_be    <= ex_mem_write ? store_be : '0;
                end else begin
                    // Non-memory op or faulting access retires immediately; here is_mem means fault.
                    wb_valid     <= 1'b1;
                    wb_rd        <= ex_rd;
                    wb_fault     <= is_mem;
                    wb_reg_write <= !is_mem && ex_reg_write && (ex_rd != '0);
                    wb_data      <= is_mem ? '0 : ex_alu_result;
                end
            end else if (mem_done) begin
                dmem_req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= lat_rd;
                wb_fault     <= 1'b0;
                wb_reg_write <= lat_mem_read && lat_reg_write && (lat_rd != '0);
                wb_data      <= lat_mem_read ? load_data : '0;
            end
        end
    end

endmodule
